// File: rtl/display_pkg.sv
// Shared types for the seven-segment write scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } digits_t;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/digit_blanker.sv
// Leading-zero blanker: 16-bit BCD in, four digit codes out, d0 never blanked.
// Latency: combinational.
// Backpressure: none.
module digit_blanker
    import display_pkg::*;
#(
    parameter logic [3:0] BLANK = DIGIT_BLANK
) (
    input  logic [15:0] value,
    input  logic        lzb_en,
    output logic [3:0]  d3,
    output logic [3:0]  d2,
    output logic [3:0]  d1,
    output logic [3:0]  d0
);

    logic z3;
    logic z2;
    logic z1;

    // A digit blanks only while it and everything above it is zero.
    assign z3 = lzb_en && (value[15:12] == 4'h0);
    assign z2 = z3 && (value[11:8] == 4'h0);
    assign z1 = z2 && (value[7:4] == 4'h0);

    assign d3 = z3 ? BLANK : value[15:12];
    assign d2 = z2 ? BLANK : value[11:8];
    assign d1 = z1 ? BLANK : value[7:4];
    assign d0 = value[3:0];

endmodule

// File: rtl/display_sched.sv
// Round-robin write scheduler for the 4-digit display, with post-result hold window.
// Latency: request sampled at edge n -> ack in cycle n+1 -> digits visible from n+2.
// Backpressure: requests wait (req held) while busy; no grants during LOAD/HOLD.
module display_sched
    import display_pkg::*;
#(
    parameter int         HOLD_CYC = 50_000_000,
    parameter logic [3:0] BLANK    = DIGIT_BLANK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        ack_b,
    input  logic        clr,
    input  logic        lzb_en,
    output logic        busy,
    output logic [3:0]  d3,
    output logic [3:0]  d2,
    output logic [3:0]  d1,
    output logic [3:0]  d0
);

    localparam int CW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;

    sched_state_t  state;
    sched_state_t  state_nxt;
    req_id_t       gnt;
    req_id_t       gnt_nxt;
    req_id_t       last_gnt;
    logic [CW-1:0] hold_cnt;
    digits_t       disp;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ack_a     = 1'b0;
        ack_b     = 1'b0;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    state_nxt = LOAD;
                    if (req_a && req_b)
                        gnt_nxt = (last_gnt == REQ_B) ? REQ_A : REQ_B;
                    else
                        gnt_nxt = req_a ? REQ_A : REQ_B;
                end
            end
            LOAD: begin
                ack_a     = (gnt == REQ_A);
                ack_b     = (gnt == REQ_B);
                state_nxt = ((gnt == REQ_B) && (HOLD_CYC > 0)) ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_cnt == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= REQ_A;
            last_gnt <= REQ_B;
            hold_cnt <= '0;
            disp     <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            if (state == LOAD)
                last_gnt <= gnt;
            if ((state == LOAD) && (state_nxt == HOLD))
                hold_cnt <= HOLD_LOAD;
            else if ((state == HOLD) && (hold_cnt != '0))
                hold_cnt <= hold_cnt - CW'(1);
            // clr beats a same-cycle load; the ack still goes out.
            if (clr)
                disp <= '0;
            else if (state == LOAD)
                disp <= (gnt == REQ_A) ? digits_t'(data_a) : digits_t'(data_b);
        end
    end

    assign busy = (state != IDLE);

    digit_blanker #(
        .BLANK(BLANK)
    ) u_blank (
        .value  (disp),
        .lzb_en (lzb_en),
        .d3     (d3),
        .d2     (d2),
        .d1     (d1),
        .d0     (d0)
    );

endmodule

// File: tb/tb_display_sched.sv
// Self-checking bench for display_sched: directed scenarios plus randomized handshaking
// traffic compared every cycle against a transaction-level reference model.
module tb_display_sched;

    localparam int HOLD = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a;
    logic [15:0] data_a;
    logic        ack_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        ack_b;
    logic        clr;
    logic        lzb_en;
    logic        busy;
    logic [3:0]  d3, d2, d1, d0;

    int errors = 0;
    int checks = 0;

    display_sched #(
        .HOLD_CYC(HOLD),
        .BLANK   (4'hF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .data_a (data_a),
        .ack_a  (ack_a),
        .req_b  (req_b),
        .data_b (data_b),
        .ack_b  (ack_b),
        .clr    (clr),
        .lzb_en (lzb_en),
        .busy   (busy),
        .d3     (d3),
        .d2     (d2),
        .d1     (d1),
        .d0     (d0)
    );

    always #5 clk = ~clk;

    // Reference model: the displayed value plus a count of remaining busy cycles
    // for the transaction in flight (1 for an A write, 1+HOLD for a B write).
    bit          model_ok = 1'b0;
    logic [15:0] m_val;
    bit          m_last;      // 0 = A, 1 = B
    bit          m_gnt;
    int          m_rem;
    bit          m_first;

    function automatic logic [15:0] fmt(input logic [15:0] v, input logic lz);
        logic [15:0] o;
        logic        lead;
        logic [3:0]  nib;
        o    = v;
        lead = lz;
        for (int i = 3; i >= 0; i--) begin
            nib = v[i*4 +: 4];
            if (i > 0 && lead && nib == 4'h0) begin
                o[i*4 +: 4] = 4'hF;
            end else begin
                o[i*4 +: 4] = nib;
                lead        = 1'b0;
            end
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_ok = 1'b1;
            m_val    = 16'h0000;
            m_last   = 1'b1;
            m_gnt    = 1'b0;
            m_rem    = 0;
            m_first  = 1'b0;
        end else if (model_ok) begin
            if (m_rem > 0) begin
                if (m_first) begin
                    m_val  = m_gnt ? data_b : data_a;
                    m_last = m_gnt;
                end
                m_rem   = m_rem - 1;
                m_first = 1'b0;
            end else if (req_a || req_b) begin
                m_gnt   = (req_a && req_b) ? !m_last : req_b;
                m_rem   = m_gnt ? 1 + HOLD : 1;
                m_first = 1'b1;
            end
            if (clr)
                m_val = 16'h0000;
        end
    end

    always @(negedge clk) begin
        logic [18:0] exp_v;
        logic [18:0] act_v;
        if (model_ok) begin
            exp_v = {m_first && !m_gnt, m_first && m_gnt, m_rem > 0, fmt(m_val, lzb_en)};
            act_v = {ack_a, ack_b, busy, d3, d2, d1, d0};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t {ack_a,ack_b,busy,digits} got=%h want=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp_v);
        end
    endtask

    function automatic logic [15:0] digits();
        return {d3, d2, d1, d0};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 50) begin
            step();
            k++;
        end
        chk(name, 16'(busy), 16'h0);
    endtask

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        int bcnt;
        bit saw_a;
        bit saw_b;

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; clr = 1'b0; lzb_en = 1'b1;
        data_a = 16'h0000; data_b = 16'h0000;
        step();
        step();
        chk("reset_digits_lzb", digits(), 16'hFFF0);
        chk("reset_busy", 16'(busy), 16'h0);
        chk("reset_acks", {14'h0, ack_a, ack_b}, 16'h0);
        rst = 1'b0;

        // Single A write, then a value needing blanking.
        lzb_en = 1'b0; req_a = 1'b1; data_a = 16'h1234;
        step();
        chk("single_ack_a", 16'(ack_a), 16'h1);
        step();
        req_a = 1'b0;
        chk("single_digits", digits(), 16'h1234);
        lzb_en = 1'b1;
        #1;
        chk("single_digits_lzb", digits(), 16'h1234);
        req_a = 1'b1; data_a = 16'h0070;
        step();
        chk("lzb_ack_a", 16'(ack_a), 16'h1);
        step();
        req_a = 1'b0;
        chk("lzb_digits", digits(), 16'hFF70);

        // Tie on a fresh reset: A first, then B.
        do_reset();
        lzb_en = 1'b0;
        req_a = 1'b1; data_a = 16'h1111; req_b = 1'b1; data_b = 16'h2222;
        step();
        chk("tie_first_ack", {14'h0, ack_a, ack_b}, 16'h2);
        step();
        req_a = 1'b0;
        step();
        chk("tie_second_ack", {14'h0, ack_a, ack_b}, 16'h1);
        step();
        req_b = 1'b0;
        chk("tie_digits", digits(), 16'h2222);
        wait_idle("tie_idle_timeout");

        // Hold window after a B write.
        do_reset();
        req_b = 1'b1; data_b = 16'h0042;
        step();
        chk("hold_ack_b", 16'(ack_b), 16'h1);
        step();
        req_b = 1'b0; req_a = 1'b1; data_a = 16'h0077;
        bcnt = 1;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            bcnt++;
            step();
        end
        chk("hold_busy_cycles", 16'(bcnt), 16'd6);
        chk("hold_no_ack_idle", 16'(ack_a), 16'h0);
        step();
        chk("hold_ack_a_after", 16'(ack_a), 16'h1);
        step();
        req_a = 1'b0;
        chk("hold_digits", digits(), 16'h0077);

        // clr coinciding with the LOAD cycle.
        req_a = 1'b1; data_a = 16'h9999;
        step();
        chk("clr_ack_a", 16'(ack_a), 16'h1);
        clr = 1'b1;
        step();
        clr = 1'b0; req_a = 1'b0;
        chk("clr_digits", digits(), 16'h0000);

        // Reset during HOLD with A pending, then non-decimal nibbles.
        req_b = 1'b1; data_b = 16'h1234;
        step();
        step();
        req_b = 1'b0; req_a = 1'b1; data_a = 16'h5555;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_hold_busy", {13'h0, busy, ack_a, ack_b}, 16'h0);
        chk("rst_hold_digits", digits(), 16'h0000);
        step();
        chk("rst_pending_ack_a", 16'(ack_a), 16'h1);
        step();
        data_a = 16'hA5B3; lzb_en = 1'b1;
        step();
        chk("odd_ack_a", 16'(ack_a), 16'h1);
        step();
        req_a = 1'b0;
        chk("odd_digits", digits(), 16'hA5B3);

        // Randomized traffic obeying the req/ack handshake.
        saw_a = 1'b0;
        saw_b = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0)
                lzb_en = ~lzb_en;
            if (req_a && saw_a) begin
                req_a = ($urandom_range(0, 3) == 0);
            end else if (!req_a && $urandom_range(0, 2) == 0) begin
                req_a  = 1'b1;
                data_a = rnd_bcd();
            end
            if (req_b && saw_b) begin
                req_b = ($urandom_range(0, 3) == 0);
            end else if (!req_b && $urandom_range(0, 4) == 0) begin
                req_b  = 1'b1;
                data_b = rnd_bcd();
            end
            step();
            saw_a = ack_a;
            saw_b = ack_b;
        end
        rst = 1'b0; clr = 1'b0; req_a = 1'b0; req_b = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
